// File: rtl/simon_decrypt.sv
// Simon 32/64 decryption core with a nibble-serial load/readout chain.
// Expands the key schedule forward to k31, then runs 32 inverse rounds while walking the schedule backwards.
module simon_decrypt (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_shift,
  input  logic [3:0] i_data,
  input  logic       i_start,
  output logic [3:0] o_data,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXPAND  = 2'd1;
  localparam logic [1:0] ST_DECRYPT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int unsigned EXPAND_STEPS = 28;
  localparam int unsigned ROUNDS       = 32;
  localparam int unsigned CNT_W        = 5;
  localparam int unsigned Z_IDX_W      = 6;

  localparam logic [15:0] C_CONST = 16'hFFFC;
  // z0 sequence; z[0] is the MSB of this literal
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  function automatic logic [15:0] ror1(input logic [15:0] a);
    return {a[0], a[15:1]};
  endfunction

  function automatic logic [15:0] ror3(input logic [15:0] a);
    return {a[2:0], a[15:3]};
  endfunction

  function automatic logic [15:0] round_f(input logic [15:0] a);
    return ({a[14:0], a[15]} & {a[7:0], a[15:8]}) ^ {a[13:0], a[15:14]};
  endfunction

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [63:0]      r_key, key_d;
  logic [31:0]      r_block, block_d;
  logic             busy_d, done_d;

  logic [15:0]        blk_x, blk_y;
  logic [15:0]        exp_t, exp_top;
  logic [15:0]        rev_t, rev_bot;
  logic [Z_IDX_W-1:0] z_fwd_idx, z_rev_idx;
  logic               z_fwd, z_rev;

  assign blk_x = r_block[31:16];
  assign blk_y = r_block[15:0];

  // Forward schedule step: produce k[i+4] from the window k[i]..k[i+3]
  assign z_fwd_idx = Z_IDX_W'(61) - Z_IDX_W'(cnt);
  assign z_fwd     = Z0[z_fwd_idx];
  assign exp_t     = ror3(r_key[63:48]) ^ r_key[31:16];
  assign exp_top   = C_CONST ^ {15'b0, z_fwd} ^ r_key[15:0] ^ exp_t ^ ror1(exp_t);

  // Reverse schedule step: recover k[27-j] from the window k[28-j]..k[31-j]
  assign z_rev_idx = Z_IDX_W'(34) + Z_IDX_W'(cnt);
  assign z_rev     = (cnt <= CNT_W'(EXPAND_STEPS - 1)) ? Z0[z_rev_idx] : 1'b0;
  assign rev_t     = ror3(r_key[47:32]) ^ r_key[15:0];
  assign rev_bot   = r_key[63:48] ^ C_CONST ^ {15'b0, z_rev} ^ rev_t ^ ror1(rev_t);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    key_d   = r_key;
    block_d = r_block;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (i_shift) begin
          key_d   = {i_data, r_key[63:4]};
          block_d = {r_key[3:0], r_block[31:4]};
          state_d = ST_IDLE;
        end else if (i_start) begin
          state_d = ST_EXPAND;
          cnt_d   = '0;
        end
      end
      ST_EXPAND: begin
        key_d = {exp_top, r_key[63:16]};
        if (cnt == CNT_W'(EXPAND_STEPS - 1)) begin
          state_d = ST_DECRYPT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_DECRYPT: begin
        block_d = {blk_y, blk_x ^ round_f(blk_y) ^ r_key[63:48]};
        key_d   = {r_key[47:0], rev_bot};
        cnt_d   = cnt + CNT_W'(1);
        if (cnt == CNT_W'(ROUNDS - 1)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_EXPAND) || (state_d == ST_DECRYPT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      r_key   <= '0;
      r_block <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      r_key   <= key_d;
      r_block <= block_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
    end
  end

  assign o_data = r_block[3:0];

endmodule

// File: tb/tb_simon_decrypt.sv
// Self-checking bench for simon_decrypt against a forward Simon 32/64 reference model.
module tb_simon_decrypt;

  localparam int unsigned N_RANDOM  = 400;
  localparam int unsigned BUSY_LEN  = 60;
  localparam int unsigned BUSY_CAP  = 100;
  localparam logic [31:0] OFF_CT    = 32'hc69be9bb;
  localparam logic [63:0] OFF_KEY   = 64'h1918111009080100;
  localparam logic [31:0] OFF_PT    = 32'h65656877;
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  logic       i_clk;
  logic       i_rst;
  logic       i_shift;
  logic [3:0] i_data;
  logic       i_start;
  logic [3:0] o_data;
  logic       o_busy;
  logic       o_done;

  int n_checks;
  int n_fail;

  simon_decrypt dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_shift (i_shift),
    .i_data  (i_data),
    .i_start (i_start),
    .o_data  (o_data),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] rotl(input logic [15:0] a, input int n);
    return 16'((a << n) | (a >> (16 - n)));
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] a, input int n);
    return 16'((a >> n) | (a << (16 - n)));
  endfunction

  // Reference: standard Simon 32/64 encryption with a fully expanded key table
  function automatic logic [31:0] model_encrypt(input logic [31:0] pt, input logic [63:0] key);
    logic [15:0] k [32];
    logic [15:0] x, y, tmp;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      tmp  = rotr(k[i-1], 3) ^ k[i-3];
      tmp  = tmp ^ rotr(tmp, 1);
      k[i] = ~k[i-4] ^ tmp ^ 16'(Z0[61-(i-4)]) ^ 16'h0003;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int r = 0; r < 32; r++) begin
      tmp = x;
      x   = y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ k[r];
      y   = tmp;
    end
    return {x, y};
  endfunction

  // Shift in ciphertext then key; returns the 8 nibbles that were emitted first
  task automatic load(input logic [31:0] ct, input logic [63:0] key, output logic [31:0] prev);
    prev = '0;
    for (int i = 0; i < 24; i++) begin
      @(negedge i_clk);
      if (i < 8) prev[4*i +: 4] = o_data;
      i_shift = 1'b1;
      i_data  = (i < 8) ? ct[4*i +: 4] : key[4*(i-8) +: 4];
    end
    @(negedge i_clk);
    i_shift = 1'b0;
    i_data  = '0;
  endtask

  task automatic run_op(input bit noisy, output int busy_cycles, output logic done_seen);
    @(negedge i_clk);
    i_start = 1'b1;
    i_shift = 1'b0;
    @(negedge i_clk);
    i_start = 1'b0;
    busy_cycles = 0;
    while (o_busy === 1'b1 && busy_cycles < int'(BUSY_CAP)) begin
      busy_cycles++;
      if (noisy && busy_cycles >= 30) begin
        i_shift = 1'($urandom);
        i_data  = 4'($urandom);
        i_start = 1'($urandom);
      end
      @(negedge i_clk);
    end
    i_shift = 1'b0;
    i_start = 1'b0;
    i_data  = '0;
    done_seen = o_done;
  endtask

  task automatic read_pt(output logic [31:0] pt);
    pt = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      pt[4*i +: 4] = o_data;
      i_shift = 1'b1;
      i_data  = 4'($urandom);
    end
    @(negedge i_clk);
    i_shift = 1'b0;
    i_data  = '0;
  endtask

  task automatic test_reset();
    logic [31:0] prev;
    load(OFF_CT, OFF_KEY, prev);
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    n_checks++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy: got %b expected 1", o_busy); end
    #2 i_rst = 1'b1;
    #1;
    n_checks++;
    if (o_data !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", o_data); end
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_checks++;
    if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", o_done); end
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_stays_idle: got %b expected 0", o_busy); end
  endtask

  task automatic test_official();
    logic [31:0] prev, pt;
    int          cycles;
    logic        done_seen;
    load(OFF_CT, OFF_KEY, prev);
    n_checks++;
    if (o_data !== OFF_CT[3:0]) begin n_fail++; $display("FAIL official_loaded_nibble: got %h expected %h", o_data, OFF_CT[3:0]); end
    run_op(1'b0, cycles, done_seen);
    n_checks++;
    if (cycles != int'(BUSY_LEN)) begin n_fail++; $display("FAIL official_busy_len: got %0d expected %0d", cycles, BUSY_LEN); end
    n_checks++;
    if (done_seen !== 1'b1) begin n_fail++; $display("FAIL official_done: got %b expected 1", done_seen); end
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL official_busy_fall: got %b expected 0", o_busy); end
    repeat (3) @(negedge i_clk);
    n_checks++;
    if (o_done !== 1'b1) begin n_fail++; $display("FAIL official_done_hold: got %b expected 1", o_done); end
    read_pt(pt);
    n_checks++;
    if (pt !== OFF_PT) begin n_fail++; $display("FAIL official_plaintext: got %h expected %h", pt, OFF_PT); end
    n_checks++;
    if (o_done !== 1'b0) begin n_fail++; $display("FAIL official_done_clear: got %b expected 0", o_done); end
  endtask

  task automatic test_busy_immunity();
    logic [31:0] prev, pt;
    int          cycles;
    logic        done_seen;
    for (int r = 0; r < 3; r++) begin
      load(OFF_CT, OFF_KEY, prev);
      run_op(1'b1, cycles, done_seen);
      n_checks++;
      if (cycles != int'(BUSY_LEN)) begin n_fail++; $display("FAIL immunity_busy_len: got %0d expected %0d", cycles, BUSY_LEN); end
      n_checks++;
      if (done_seen !== 1'b1) begin n_fail++; $display("FAIL immunity_done: got %b expected 1", done_seen); end
      read_pt(pt);
      n_checks++;
      if (pt !== OFF_PT) begin n_fail++; $display("FAIL immunity_plaintext: got %h expected %h", pt, OFF_PT); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] prev, pt;
    int          cycles;
    logic        done_seen;
    load(OFF_CT, OFF_KEY, prev);
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (39) @(negedge i_clk);
    n_checks++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_busy: got %b expected 1", o_busy); end
    #2 i_rst = 1'b1;
    #1;
    n_checks++;
    if ({o_data, o_busy, o_done} !== 6'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got data=%h busy=%b done=%b expected all 0", o_data, o_busy, o_done);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    n_checks++;
    if ({o_busy, o_done} !== 2'b00) begin
      n_fail++; $display("FAIL midreset_idle: got busy=%b done=%b expected 0 0", o_busy, o_done);
    end
    load(OFF_CT, OFF_KEY, prev);
    run_op(1'b0, cycles, done_seen);
    n_checks++;
    if (cycles != int'(BUSY_LEN) || done_seen !== 1'b1) begin
      n_fail++; $display("FAIL midreset_rerun_timing: got busy=%0d done=%b expected %0d 1", cycles, done_seen, BUSY_LEN);
    end
    read_pt(pt);
    n_checks++;
    if (pt !== OFF_PT) begin n_fail++; $display("FAIL midreset_plaintext: got %h expected %h", pt, OFF_PT); end
  endtask

  task automatic test_shift_start();
    logic [31:0] ct, prev;
    logic [63:0] key;
    for (int r = 0; r < 4; r++) begin
      ct  = $urandom;
      key = {$urandom, $urandom};
      load(ct, key, prev);
      n_checks++;
      if (o_data !== ct[3:0]) begin n_fail++; $display("FAIL shiftstart_loaded: got %h expected %h", o_data, ct[3:0]); end
      @(negedge i_clk);
      i_shift = 1'b1;
      i_start = 1'b1;
      i_data  = 4'($urandom);
      @(negedge i_clk);
      i_shift = 1'b0;
      i_start = 1'b0;
      n_checks++;
      if (o_data !== ct[7:4]) begin n_fail++; $display("FAIL shiftstart_shifted: got %h expected %h", o_data, ct[7:4]); end
      repeat (3) @(negedge i_clk);
      n_checks++;
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL shiftstart_no_start: got busy=%b expected 0", o_busy); end
    end
  endtask

  task automatic test_roundtrip();
    logic [31:0] pt, ct, prev, exp_prev, last;
    logic [63:0] key;
    int          cycles;
    logic        done_seen;
    exp_prev = '0;
    for (int n = 0; n < int'(N_RANDOM); n++) begin
      pt  = $urandom;
      key = {$urandom, $urandom};
      ct  = model_encrypt(pt, key);
      load(ct, key, prev);
      if (n > 0) begin
        n_checks++;
        if (prev !== exp_prev) begin
          n_fail++; $display("FAIL roundtrip_plaintext run %0d: got %h expected %h", n - 1, prev, exp_prev);
        end
      end
      run_op(1'b0, cycles, done_seen);
      n_checks++;
      if (cycles != int'(BUSY_LEN) || done_seen !== 1'b1) begin
        n_fail++; $display("FAIL roundtrip_timing run %0d: got busy=%0d done=%b expected %0d 1", n, cycles, done_seen, BUSY_LEN);
      end
      exp_prev = pt;
    end
    read_pt(last);
    n_checks++;
    if (last !== exp_prev) begin n_fail++; $display("FAIL roundtrip_last: got %h expected %h", last, exp_prev); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_rst    = 1'b1;
    i_shift  = 1'b0;
    i_start  = 1'b0;
    i_data   = '0;
    #3;
    n_checks++;
    if ({o_data, o_busy, o_done} !== 6'b0) begin
      n_fail++; $display("FAIL initial_reset: got data=%h busy=%b done=%b expected all 0", o_data, o_busy, o_done);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    test_reset();
    test_official();
    test_busy_immunity();
    test_reset_mid();
    test_shift_start();
    test_roundtrip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
